axi_wr_burst_arbiter: RTL
=========================

Name: axi_wr_burst_arbiter

Overview:
- Shares one AXI3 write master port (AW/W/B) between NUM_REQ burst requesters, e.g. the pattern/frame generator and a fill or overlay engine writing the same DDR frame buffer.
- Grants one requester at a time, round-robin. The grant is held from address issue through the write response, so bursts never interleave.
- Generates AW, W-last and B handshakes itself. Requesters see a simple req/ack, data-stream, done interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width.
- LEN_W, 4, burst length field width (AXI3: awlen 0..15).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester burst request; held until ack.
- req_addr  in  NUM_REQ*ADDR_W  packed burst start addresses; requester i occupies slice i.
- req_len  in  NUM_REQ*LEN_W  packed awlen values (beats-1).
- ack  out  NUM_REQ  one-cycle pulse when the AW handshake completes for requester i.
- wdata_in  in  NUM_REQ*DATA_W  packed write data.
- wstrb_in  in  NUM_REQ*(DATA_W/8)  packed strobes.
- wvalid_in  in  NUM_REQ  per-requester data valid.
- wready_out  out  NUM_REQ  data ready; only the granted bit can be 1.
- done  out  NUM_REQ  one-cycle pulse on B handshake for requester i.
- bresp_out  out  2  bresp captured with done; holds until the next done.
- busy  out  1  high whenever state != IDLE.
- m_axi_awaddr/awlen/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready/wlast, m_axi_bresp/bvalid/bready: standard AXI3 write master signals.
- awsize = log2(DATA_W/8), awburst = INCR, awprot/awcache/awlock/awqos/awregion = 0, all constant.

Behaviour:
- Reset (aresetn low at a clock edge) forces:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, bresp_out = 0.
  - ack, done, wready_out, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready all 0.
  - m_axi_awaddr, m_axi_awlen, m_axi_wdata, m_axi_wstrb all 0.
- Reset mid-burst abandons the transaction; this is only legal with a system-wide reset of the interconnect.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit searching upward from rr_ptr, wrapping.
  - Register grant index, addr and len; go to ADDR next cycle. Selection latency is 1 cycle.
  - A req that drops before selection is ignored with no side effect.
- ADDR:
  - awvalid = 1, with awaddr/awlen from the registered values. These stay stable while awready is low.
  - On awvalid & awready: pulse ack[grant], clear beat_cnt, go to DATA.
- DATA:
  - m_axi_wvalid = wvalid_in[grant]; wdata/wstrb are muxed from slice grant.
  - wready_out[grant] = m_axi_wready; all other wready_out bits = 0.
  - wlast = (beat_cnt == len), generated internally; requesters do not supply last.
  - On each wvalid & wready: beat_cnt increments. On the beat where wlast is high, go to RESP.
  - wvalid_in low stalls with no beat counted; no timeout.
- RESP:
  - bready = 1.
  - On bvalid: pulse done[grant], latch bresp_out = m_axi_bresp, set rr_ptr = grant+1 (mod NUM_REQ), go to IDLE.
- Throughput: at most one burst in flight; minimum 1 idle cycle between bursts.
- Simultaneous requests: round-robin ensures that with both requesters continuously requesting, grants alternate 0,1,0,1.
- AW-before-W ordering: W beats are never presented before the AW handshake.
- bresp is not interpreted; SLVERR/DECERR are passed to the requester only.

Decomposition:
- Shared package axi_tg_pkg:
  - State encoding constants IDLE/ADDR/DATA/RESP.
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR, SIZE_OF_BYTE = 8.
- One sub-module rr_pick: combinational round-robin priority pick, inputs req vector and rr_ptr, outputs index and valid. It is reused by the later read-side arbiter.

Test Plan:
- Single requester 0, addr 0x10000000, len 15, awready/wready always 1:
  - awvalid for 1 cycle; 16 beats; wlast only on beat 16; done[0] one cycle after bvalid; bresp_out = 00.
- req = 2'b11 held for 4 bursts, len 3:
  - AW addresses alternate r0,r1,r0,r1; ack order 0,1,0,1; no W beats interleave.
- awready delayed 5 cycles:
  - awaddr/awlen stable for all 6 awvalid cycles; no wready_out before ack.
- Granted requester drops wvalid_in on beats 3–5 of len 7; m_axi_wready toggles:
  - exactly 8 beats accepted; beat data in order; wlast coincides with the 8th handshake.
- bvalid with bresp = 2'b10:
  - done pulses; bresp_out = 10 held until the next done.
- aresetn low during DATA beat 6:
  - next cycle all outputs are at reset values; state IDLE; rr_ptr = 0; a new req is granted normally after release.

Source files
------------

// File: rtl/axi_tg_pkg.sv
// Shared definitions for the AXI traffic-generator write/read arbiters:
// FSM state encoding, AXI burst/response constants and a transfer-size helper.
package axi_tg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam int         SIZE_OF_BYTE = 8;

   // AxSIZE encoding: log2 of the number of bytes per beat.
   function automatic logic [2:0] axsize(input int data_w);
      axsize = '0;
      for (int k = 0; k < 8; k++) begin
         if ((1 << k) == (data_w / SIZE_OF_BYTE)) axsize = 3'(k);
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_vld
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_pos;

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      w_sum = '0;
      w_pos = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         w_pos = w_sum[IDX_W-1:0];
         if (!o_vld && i_req[w_pos]) begin
            o_vld = 1'b1;
            o_idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/axi_wr_burst_arbiter.sv
// Round-robin arbiter sharing one AXI3 write master among NUM_REQ burst requesters;
// a grant is held from AW issue through the B response so bursts never interleave.
module axi_wr_burst_arbiter
   import axi_tg_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int LEN_W   = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]      req_len,
   output logic [NUM_REQ-1:0]            ack,
   input  logic [NUM_REQ*DATA_W-1:0]     wdata_in,
   input  logic [NUM_REQ*(DATA_W/8)-1:0] wstrb_in,
   input  logic [NUM_REQ-1:0]            wvalid_in,
   output logic [NUM_REQ-1:0]            wready_out,
   output logic [NUM_REQ-1:0]            done,
   output logic [1:0]                    bresp_out,
   output logic                          busy,
   output logic [ADDR_W-1:0]             m_axi_awaddr,
   output logic [LEN_W-1:0]              m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic [2:0]                    m_axi_awprot,
   output logic [3:0]                    m_axi_awcache,
   output logic [1:0]                    m_axi_awlock,
   output logic [3:0]                    m_axi_awqos,
   output logic [3:0]                    m_axi_awregion,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [DATA_W-1:0]             m_axi_wdata,
   output logic [DATA_W/8-1:0]           m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic                          m_axi_wlast,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int STRB_W = DATA_W / SIZE_OF_BYTE;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_grant, r_rr_ptr, w_pick_idx;
   logic               w_pick_vld;
   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-1:0]   r_len, r_beat_cnt;
   logic [NUM_REQ-1:0] r_ack, r_done;
   logic [1:0]         r_bresp;
   logic               w_aw_hs, w_w_hs, w_b_hs;

   logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
   logic [LEN_W-1:0]   w_len   [NUM_REQ];
   logic [DATA_W-1:0]  w_wdata [NUM_REQ];
   logic [STRB_W-1:0]  w_wstrb [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign w_len[g]   = req_len[g*LEN_W +: LEN_W];
      assign w_wdata[g] = wdata_in[g*DATA_W +: DATA_W];
      assign w_wstrb[g] = wstrb_in[g*STRB_W +: STRB_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_vld   (w_pick_vld)
   );

   assign ack            = r_ack;
   assign done           = r_done;
   assign bresp_out      = r_bresp;
   assign busy           = (r_state != IDLE);
   assign m_axi_awaddr   = r_addr;
   assign m_axi_awlen    = r_len;
   assign m_axi_awsize   = axsize(DATA_W);
   assign m_axi_awburst  = BURST_INCR;
   assign m_axi_awprot   = '0;
   assign m_axi_awcache  = '0;
   assign m_axi_awlock   = '0;
   assign m_axi_awqos    = '0;
   assign m_axi_awregion = '0;

   always_ff @(posedge aclk) begin
      if (!aresetn) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // W signals are only routed in DATA, so nothing reaches the bus ahead of AW.
   always_comb begin
      w_state_nxt   = r_state;
      w_aw_hs       = 1'b0;
      w_w_hs        = 1'b0;
      w_b_hs        = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_wdata   = '0;
      m_axi_wstrb   = '0;
      m_axi_bready  = 1'b0;
      wready_out    = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) w_state_nxt = ADDR;
         end
         ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) begin
               w_aw_hs     = 1'b1;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            m_axi_wvalid        = wvalid_in[r_grant];
            m_axi_wdata         = w_wdata[r_grant];
            m_axi_wstrb         = w_wstrb[r_grant];
            m_axi_wlast         = (r_beat_cnt == r_len);
            wready_out[r_grant] = m_axi_wready;
            w_w_hs              = m_axi_wvalid && m_axi_wready;
            if (w_w_hs && m_axi_wlast) w_state_nxt = RESP;
         end
         RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               w_b_hs      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_beat_cnt <= '0;
         r_ack      <= '0;
         r_done     <= '0;
         r_bresp    <= RESP_OKAY;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         if (r_state == IDLE && w_pick_vld) begin
            r_grant <= w_pick_idx;
            r_addr  <= w_addr[w_pick_idx];
            r_len   <= w_len[w_pick_idx];
         end
         if (w_aw_hs) begin
            r_ack[r_grant] <= 1'b1;
            r_beat_cnt     <= '0;
         end
         if (w_w_hs) r_beat_cnt <= r_beat_cnt + 1'b1;
         // The pointer only moves on completion, so the next search starts past the winner.
         if (w_b_hs) begin
            r_done[r_grant] <= 1'b1;
            r_bresp         <= m_axi_bresp;
            r_rr_ptr        <= (r_grant == IDX_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
         end
      end
   end

endmodule
